uart_rx: RTL

//  UART receiver: the far end of the transmit path. Samples the asynchronous rx line
//  (8N1, LSB first) at mid-bit, rebuilds one byte per frame and presents it through a
//  one-entry holding register with a valid/ready handshake towards the AXI4-Lite register block.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_sync2.sv | 27 ++
 rtl/uart_rx.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame-level constants
// common to the transmit and receive paths.
package uart_pkg;

  localparam int unsigned UART_DATA_W   = 8;
  localparam logic        UART_IDLE_LVL  = 1'b1;
  localparam logic        UART_START_LVL = 1'b0;
  localparam logic        UART_STOP_LVL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input; RESET_VAL sets the
// value both flops take under reset.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first, mid-bit sampling, one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 50000000,
  parameter int unsigned BAUD_RATE  = 9600
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx,
  output logic [UART_DATA_W-1:0] data_out,
  output logic                   valid,
  input  logic                   ready,
  output logic                   frame_err,
  output logic                   overrun,
`ifdef UART_RX_PARITY_EN
  output logic                   parity_err,
`endif
  output logic                   busy
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic                   w_rx_s;
  logic                   r_rx_d;
  rx_state_e              r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [2:0]             r_idx, w_idx_nxt;
  logic [UART_DATA_W-1:0] r_shift, w_shift_nxt;
  logic                   w_stop_ok;
  logic                   w_stop_bad;
`ifdef UART_RX_PARITY_EN
  logic                   r_par, w_par_nxt;
  logic                   w_par_bad;
`endif

  uart_sync2 #(.RESET_VAL(UART_IDLE_LVL)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_stop_ok   = 1'b0;
    w_stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_nxt   = r_par;
    w_par_bad   = 1'b0;
`endif
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        // Only a fresh 1->0 edge starts a frame, so a held-low break never retriggers.
        if (!w_rx_s && r_rx_d) w_state_nxt = START;
      end
      START: begin
        if (r_cnt == HALF_M1) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = (w_rx_s == UART_START_LVL) ? DATA : IDLE;
        end
      end
      DATA: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rx_s, r_shift[UART_DATA_W-1:1]};
          w_idx_nxt   = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_nxt   = '0;
          w_par_nxt   = w_rx_s;
          w_state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
          if (w_rx_s != UART_STOP_LVL) begin
            w_stop_bad = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (^{r_shift, r_par}) begin
            w_par_bad = 1'b1;
`endif
          end else begin
            w_stop_ok = 1'b1;
          end
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_rx_d  <= UART_IDLE_LVL;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_rx_d  <= w_rx_s;
`ifdef UART_RX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err  <= w_stop_bad;
      overrun    <= w_stop_ok && valid && !ready;
`ifdef UART_RX_PARITY_EN
      parity_err <= w_par_bad;
`endif
      // Same-cycle delivery wins over the handshake clear so the new byte is not lost.
      if (w_stop_ok && (!valid || ready)) begin
        data_out <= r_shift;
        valid    <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

  assign busy = (r_state != IDLE);

endmodule
